// File: rtl/ot_receiver.sv
// ot_receiver: 8N1 UART receiver, 16x oversampled through a shared clock enable.
// Optional feature: define RX_GLITCH_FILTER_EN to add a majority-of-3 filter on the
// synchronised line so that single-sample pulses cannot start a frame.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle, waiting for a low sample (start edge)
// START | counting to mid start bit, confirming it is still low
// DATA  | sampling DATA_BITS data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high = good frame, low = framing error
module ot_receiver #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_50m,
  input  logic                 rstn,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_m;
  logic                 rx_s;
  logic                 rx_line;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef RX_GLITCH_FILTER_EN
  logic [2:0] filt_q;

  // Three-sample history on the oversampling enable; majority vote drops 1-sample pulses.
  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      filt_q <= 3'b111;
    end else if (clken) begin
      filt_q <= {filt_q[1:0], rx_s};
    end
  end

  assign rx_line = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
`else
  assign rx_line = rx_s;
`endif

  assign rx_busy = (state != IDLE);

  // Frame FSM with registered word, ready, overrun and framing-error outputs.
  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      bit_idx   <= '0;
      shift_q   <= '0;
      data_out  <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // A completing good frame below overrides this clear of rdy.
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (clken) begin
        case (state)
          IDLE: begin
            if (!rx_line) begin
              state <= START;
              cnt   <= 4'd0;
            end
          end
          START: begin
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              if (!rx_line) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          DATA: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              // Shift in from the top so the first bit lands in bit 0 after DATA_BITS shifts.
              shift_q <= (shift_q >> 1) | (DATA_BITS'(rx_line) << (DATA_BITS - 1));
              if (bit_idx == LAST_IDX) begin
                state <= STOP;
                cnt   <= 4'd0;
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end
          STOP: begin
            if (cnt == 4'd15) begin
              state <= IDLE;
              cnt   <= 4'd0;
              if (rx_line) begin
                data_out <= shift_q;
                rdy      <= 1'b1;
                if (rdy && !rdy_clr) begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ot_receiver.sv
// Directed bench for ot_receiver: clean frames, back-to-back frames, framing error,
// overrun, idle-line glitches and reset mid-frame.
module tb_ot_receiver;

  logic       clk_50m = 1'b0;
  logic       rstn    = 1'b0;
  logic       clken   = 1'b0;
  logic       rx      = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data_out;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int n_vec = 0;
  int n_err = 0;

  int busy_rise = 0;
  int busy_fall = 0;
  int fe_hi     = 0;
  logic busy_d  = 1'b0;

  ot_receiver #(.DATA_BITS(8)) dut (
    .clk_50m  (clk_50m),
    .rstn     (rstn),
    .clken    (clken),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data_out (data_out),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  // 16x enable: one cycle in four, changed just after the rising edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk_50m);
      #1;
      clken = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Edge and pulse monitors sampled on the falling edge.
  always @(negedge clk_50m) begin
    if (rx_busy && !busy_d) busy_rise <= busy_rise + 1;
    if (!rx_busy && busy_d) busy_fall <= busy_fall + 1;
    busy_d <= rx_busy;
    if (frame_err) fe_hi <= fe_hi + 1;
  end

  task automatic wait_clken();
    int guard;
    guard = 0;
    @(negedge clk_50m);
    while (!clken) begin
      guard++;
      if (guard > 64) begin
        $display("FAIL clken_timeout: clken held low for %0d cycles, limit 64", guard);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "clken stalled");
      end
      @(negedge clk_50m);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (16) wait_clken();
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    send_bit(stop_val);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk_50m);
    if (data_out !== 8'h00) begin $display("FAIL reset_data: got %h want 00", data_out); n_err++; end
    n_vec++;
    if (rdy !== 1'b0) begin $display("FAIL reset_rdy: got %b want 0", rdy); n_err++; end
    n_vec++;
    if (frame_err !== 1'b0) begin $display("FAIL reset_fe: got %b want 0", frame_err); n_err++; end
    n_vec++;
    if (overrun !== 1'b0) begin $display("FAIL reset_ovr: got %b want 0", overrun); n_err++; end
    n_vec++;
    if (rx_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", rx_busy); n_err++; end
    n_vec++;
    rstn = 1'b1;
    repeat (4) wait_clken();
  endtask

  task automatic test_basic();
    int fe0;
    fe0 = fe_hi;
    send_frame(8'hA5, 1'b1);
    @(negedge clk_50m);
    if (data_out !== 8'hA5) begin $display("FAIL basic_data: got %h want a5", data_out); n_err++; end
    n_vec++;
    if (rdy !== 1'b1) begin $display("FAIL basic_rdy: got %b want 1", rdy); n_err++; end
    n_vec++;
    if (fe_hi - fe0 !== 0) begin $display("FAIL basic_fe: got %0d pulses want 0", fe_hi - fe0); n_err++; end
    n_vec++;
    if (overrun !== 1'b0) begin $display("FAIL basic_ovr: got %b want 0", overrun); n_err++; end
    n_vec++;
    pulse_clr();
    if (rdy !== 1'b0) begin $display("FAIL basic_clr_rdy: got %b want 0", rdy); n_err++; end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int r0, f0;
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h3C;
    r0 = busy_rise;
    f0 = busy_fall;
    for (int k = 0; k < 3; k++) begin
      send_frame(words[k], 1'b1);
      @(negedge clk_50m);
      if (data_out !== words[k]) begin
        $display("FAIL b2b_data%0d: got %h want %h", k, data_out, words[k]); n_err++;
      end
      n_vec++;
      if (rdy !== 1'b1) begin $display("FAIL b2b_rdy%0d: got %b want 1", k, rdy); n_err++; end
      n_vec++;
      rdy_clr = 1'b1;
      @(negedge clk_50m);
      rdy_clr = 1'b0;
    end
    @(negedge clk_50m);
    if (busy_fall - f0 !== 3) begin $display("FAIL b2b_busy_fall: got %0d want 3", busy_fall - f0); n_err++; end
    n_vec++;
    if (busy_rise - r0 !== 3) begin $display("FAIL b2b_busy_rise: got %0d want 3", busy_rise - r0); n_err++; end
    n_vec++;
    if (rdy !== 1'b0) begin $display("FAIL b2b_final_rdy: got %b want 0", rdy); n_err++; end
    n_vec++;
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_hi;
    send_frame(8'h55, 1'b0);
    repeat (24) wait_clken();
    if (fe_hi - fe0 !== 1) begin $display("FAIL ferr_pulse: got %0d cycles want 1", fe_hi - fe0); n_err++; end
    n_vec++;
    if (data_out !== 8'h3C) begin $display("FAIL ferr_data: got %h want 3c", data_out); n_err++; end
    n_vec++;
    if (rdy !== 1'b0) begin $display("FAIL ferr_rdy: got %b want 0", rdy); n_err++; end
    n_vec++;
    if (rx_busy !== 1'b0) begin $display("FAIL ferr_busy: got %b want 0", rx_busy); n_err++; end
    n_vec++;
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    @(negedge clk_50m);
    if (overrun !== 1'b0) begin $display("FAIL ovr_first: got %b want 0", overrun); n_err++; end
    n_vec++;
    send_frame(8'h22, 1'b1);
    @(negedge clk_50m);
    if (data_out !== 8'h22) begin $display("FAIL ovr_data: got %h want 22", data_out); n_err++; end
    n_vec++;
    if (rdy !== 1'b1) begin $display("FAIL ovr_rdy: got %b want 1", rdy); n_err++; end
    n_vec++;
    if (overrun !== 1'b1) begin $display("FAIL ovr_flag: got %b want 1", overrun); n_err++; end
    n_vec++;
    pulse_clr();
    if (rdy !== 1'b0) begin $display("FAIL ovr_clr_rdy: got %b want 0", rdy); n_err++; end
    n_vec++;
    if (overrun !== 1'b0) begin $display("FAIL ovr_clr_flag: got %b want 0", overrun); n_err++; end
    n_vec++;
  endtask

  task automatic test_glitch();
    int fe0, r0;
    fe0 = fe_hi;
    rx = 1'b0;
    repeat (4) wait_clken();
    rx = 1'b1;
    repeat (24) wait_clken();
    if (rdy !== 1'b0) begin $display("FAIL glitch4_rdy: got %b want 0", rdy); n_err++; end
    n_vec++;
    if (rx_busy !== 1'b0) begin $display("FAIL glitch4_busy: got %b want 0", rx_busy); n_err++; end
    n_vec++;
    if (fe_hi - fe0 !== 0) begin $display("FAIL glitch4_fe: got %0d want 0", fe_hi - fe0); n_err++; end
    n_vec++;
    r0 = busy_rise;
    rx = 1'b0;
    wait_clken();
    rx = 1'b1;
    repeat (24) wait_clken();
`ifdef RX_GLITCH_FILTER_EN
    if (busy_rise - r0 !== 0) begin $display("FAIL glitch1_start: got %0d starts want 0", busy_rise - r0); n_err++; end
`else
    if (busy_rise - r0 !== 1) begin $display("FAIL glitch1_start: got %0d starts want 1", busy_rise - r0); n_err++; end
`endif
    n_vec++;
    if (rx_busy !== 1'b0 || rdy !== 1'b0) begin
      $display("FAIL glitch1_idle: got busy=%b rdy=%b want 0 0", rx_busy, rdy); n_err++;
    end
    n_vec++;
    if (data_out !== 8'h22) begin $display("FAIL glitch_data: got %h want 22", data_out); n_err++; end
    n_vec++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w;
    w = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    rx = w[3];
    repeat (8) wait_clken();
    if (rx_busy !== 1'b1) begin $display("FAIL mid_busy: got %b want 1", rx_busy); n_err++; end
    n_vec++;
    rstn = 1'b0;
    repeat (2) @(negedge clk_50m);
    if (data_out !== 8'h00) begin $display("FAIL mid_rst_data: got %h want 00", data_out); n_err++; end
    n_vec++;
    if (rdy !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin
      $display("FAIL mid_rst_flags: got rdy=%b ovr=%b fe=%b busy=%b want 0 0 0 0",
               rdy, overrun, frame_err, rx_busy);
      n_err++;
    end
    n_vec++;
    rx = 1'b1;
    @(negedge clk_50m);
    rstn = 1'b1;
    repeat (20) wait_clken();
    send_frame(8'h81, 1'b1);
    @(negedge clk_50m);
    if (data_out !== 8'h81) begin $display("FAIL post_rst_data: got %h want 81", data_out); n_err++; end
    n_vec++;
    if (rdy !== 1'b1 || overrun !== 1'b0) begin
      $display("FAIL post_rst_flags: got rdy=%b ovr=%b want 1 0", rdy, overrun); n_err++;
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
